program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter INSTR_MEM_SIZE, default 32, giving the instruction-memory depth in 32-bit words (range 2..256).
REQ-002 The block SHALL have derived local parameter ADDR_WIDTH, equal to clog2(INSTR_MEM_SIZE), giving the word-address width.
REQ-003 Port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port rx_valid  input  1  the byte on rx_data is offered.
REQ-006 Port rx_data  input  8  the offered byte of the program stream.
REQ-007 Port rx_ready  output  1  the loader accepts a byte this cycle; a byte transfers when rx_valid and rx_ready are both high.
REQ-008 Port imem_we  output  1  one-cycle write strobe to the instruction memory.
REQ-009 Port imem_addr  output  ADDR_WIDTH  word index of the write.
REQ-010 Port imem_wdata  output  32  instruction word to write.
REQ-011 Port cpu_reset  output  1  reset to the downstream CPU; high until the load succeeds.
REQ-012 Port done  output  1  load completed successfully.
REQ-013 Port error  output  1  load failed; sticky until reset.

Function
REQ-014 The stream format SHALL be: header byte N (word count); then 4*N bytes, each word most-significant byte first; then one checksum byte only when LOADER_CHECKSUM_EN is defined.
REQ-015 The block SHALL implement the states HEADER, DATA, CHECK, DONE and ERROR; the state after reset is HEADER.
REQ-016 rx_ready SHALL be high in HEADER, DATA and CHECK, and low in DONE and ERROR.
REQ-017 In HEADER, on an accepted byte: if N==0 or N>INSTR_MEM_SIZE, the next state SHALL be ERROR; otherwise the block latches N, clears the word and byte counters, and goes to DATA.
REQ-018 In DATA, bytes SHALL shift into a 32-bit assembly register as {reg[23:0], rx_data}, counted by a 2-bit byte counter.
REQ-019 On acceptance of the 4th byte of a word, in the next cycle imem_we SHALL be 1 for exactly one cycle, imem_wdata SHALL be the assembled word, and imem_addr SHALL be the word counter; the word counter then increments.
REQ-020 rx_ready SHALL stay high during the write cycle; back-to-back bytes are never stalled.
REQ-021 Gaps in rx_valid SHALL only delay progress and SHALL NOT change the content or order of writes.
REQ-022 After the 4th byte of word N-1 is accepted, the next state SHALL be CHECK if LOADER_CHECKSUM_EN is defined, else DONE.
REQ-023 Without checksum, done SHALL rise and cpu_reset SHALL fall in the cycle after the final imem_we pulse.
REQ-024 In CHECK, on an accepted byte: if it equals the XOR of all 4*N payload bytes (header excluded), the next state SHALL be DONE, else ERROR; done or error SHALL assert in the cycle after acceptance.
REQ-025 DONE and ERROR SHALL be terminal until reset; in them, bytes are ignored and imem_we stays 0.
REQ-026 Entering ERROR SHALL NOT roll back writes already performed; cpu_reset SHALL stay 1 in ERROR.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set state=HEADER, all counters and the checksum accumulator to 0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0 and cpu_reset=1; rx_ready SHALL be 1 from the first cycle after reset.
REQ-029 Reset asserted mid-load SHALL abort the load with no further write; the next load restarts at address 0.

Configuration
REQ-030 With macro LOADER_CHECKSUM_EN defined, the block SHALL include the CHECK state and the XOR accumulator, cleared in HEADER and updated on every accepted DATA byte.
REQ-031 With LOADER_CHECKSUM_EN undefined, the block SHALL omit the CHECK state and the accumulator, and SHALL NOT expect a trailing checksum byte.

Structure
REQ-032 The state encodings (LDR_HEADER, LDR_DATA, LDR_CHECK, LDR_DONE, LDR_ERROR) SHALL be defined in the shared constants.h.
REQ-033 One sub-module, word_assembler, SHALL hold the shift register, the byte counter and the write strobe; the FSM, word counter and checksum SHALL remain in program_loader.

Verification
REQ-034 Checksum on, IMS=32, continuous stream 02 20 01 00 05 00 22 10 20 36 -> writes (0,0x20010005) then (1,0x00221020); done=1, cpu_reset=0, error=0.
REQ-035 Same stream with checksum byte 0x37 -> both writes occur; error=1, done=0, cpu_reset=1, rx_ready=0.
REQ-036 Header 0x00, then a separate run with header 0x21 (33>32) -> error=1 the cycle after the header is accepted; no imem_we pulse.
REQ-037 The REQ-034 stream with rx_valid toggling every other cycle -> identical writes and final flags; reset pulsed after the 5th byte -> no write occurs, and a new stream writes starting at addr 0.
REQ-038 Checksum off, N=32 with word k = 0x1000_0000+k -> 32 pulses, last at addr 31 with data 0x1000001F; done the cycle after the last pulse; extra bytes are ignored.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader.
// Holds the loader FSM state encoding and a helper that says in which
// states the loader is willing to take a byte from the stream.
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package program_loader_pkg;

    typedef enum logic [2:0] {
        LDR_HEADER = 3'd0,
        LDR_DATA   = 3'd1,
        LDR_CHECK  = 3'd2,
        LDR_DONE   = 3'd3,
        LDR_ERROR  = 3'd4
    } ldr_state_e;

    // The loader listens for bytes everywhere except the two terminal states.
    function automatic logic ldr_accepting(input ldr_state_e s);
        return (s == LDR_HEADER) || (s == LDR_DATA) || (s == LDR_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: packs stream bytes into 32-bit words, MSB first.
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   clear             - restart assembly at byte 0 (new load)
//   push, byte_data   - one accepted payload byte
//   last_byte         - the next pushed byte completes a word
//   we, wdata         - registered one-cycle write strobe and finished word
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        we,
    output logic [31:0] wdata
);

    // Only the first three bytes of a word need holding; the fourth goes
    // straight into the output word together with them.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        if (clear) begin
            shift_d    = '0;
            byte_cnt_d = '0;
        end else if (push) begin
            shift_d    = {shift_q[15:0], byte_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                we_d    = 1'b1;
                wdata_d = {shift_q, byte_data};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
        end
    end

    assign last_byte = (byte_cnt_q == 2'd3);
    assign we        = we_q;
    assign wdata     = wdata_q;

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a program over a byte stream and writes it into
// instruction memory, holding the CPU in reset until the load succeeds.
// Stream: header N, then 4*N bytes (words MSB first), then one XOR
// checksum byte when LOADER_CHECKSUM_EN is defined.
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
// are both high; rx_ready never depends on rx_valid.
// Ports:
//   clock, reset           - clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready - byte stream input
//   imem_we/addr/wdata     - registered instruction-memory write port
//   cpu_reset, done, error - load status (error sticky until reset)
//   dbg_state              - current FSM state for observation
module program_loader
    import program_loader_pkg::*;
#(
    parameter  int INSTR_MEM_SIZE = 32,
    localparam int ADDR_WIDTH     = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output ldr_state_e            dbg_state
);

    // One extra bit so the counter can reach INSTR_MEM_SIZE itself.
    localparam int CNT_W = ADDR_WIDTH + 1;

    ldr_state_e            state_q, state_d;
    logic [7:0]            n_q, n_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_reset_q, cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic accept;
    logic asm_clear, asm_push, asm_last;

    assign accept = rx_valid & rx_ready_q;

    word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (asm_clear),
        .push      (asm_push),
        .byte_data (rx_data),
        .last_byte (asm_last),
        .we        (imem_we),
        .wdata     (imem_wdata)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        done_d     = done_q;
        error_d    = error_q;
        asm_clear  = 1'b0;
        asm_push   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            LDR_HEADER: begin
                if (accept) begin
                    if (rx_data == 8'd0 || int'(rx_data) > INSTR_MEM_SIZE) begin
                        state_d = LDR_ERROR;
                        error_d = 1'b1;
                    end else begin
                        n_d        = rx_data;
                        word_cnt_d = '0;
                        asm_clear  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                        state_d    = LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                if (accept) begin
                    asm_push = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ rx_data;
`endif
                    if (asm_last) begin
                        // Address is registered alongside the strobe so all
                        // three write outputs change on the same edge.
                        addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (int'(word_cnt_q) == int'(n_q) - 1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = LDR_CHECK;
`else
                            state_d = LDR_DONE;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LDR_CHECK: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = LDR_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LDR_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            // Without a checksum, done is raised one cycle after entering
            // DONE, i.e. in the cycle after the final write strobe.
            LDR_DONE: done_d = 1'b1;
            default: ;
        endcase
        rx_ready_d  = ldr_accepting(state_d);
        cpu_reset_d = ~done_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LDR_HEADER;
            n_q         <= '0;
            word_cnt_q  <= '0;
            addr_q      <= '0;
            rx_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            addr_q      <= addr_d;
            rx_ready_q  <= rx_ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign imem_addr = addr_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed loads plus random loads, with the
// expected write sequence and final flags derived from the stream format.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int IMS = 32;
    localparam int AW  = $clog2(IMS);

    logic          clock = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    ldr_state_e    dbg_state;

    program_loader #(.INSTR_MEM_SIZE(IMS)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] words_q[$];
    int          last_we_cyc = -1;
    int          done_rise_cyc = -1;
    int          last_accept_cyc = -1;
    int          data_last_accept = -1;
    logic [31:0] last_we_addr = '0;
    logic [31:0] last_we_data = '0;
    logic        prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
                end else begin
                    check("write_addr", 32'(imem_addr), exp_addr_q.pop_front());
                    check("write_data", imem_wdata, exp_q.pop_front());
                end
                last_we_cyc  = cyc;
                last_we_addr = 32'(imem_addr);
                last_we_data = imem_wdata;
            end
            if (done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
        end
        prev_done = done;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (t >= 40) check("ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clock);
        last_accept_cyc = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic offer_ignored(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        check("writes_pending_before_reset", exp_q.size(), 0);
        exp_q.delete();
        exp_addr_q.delete();
        rx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        done_rise_cyc = -1;
        last_we_cyc = -1;
    endtask

    task automatic check_reset_state();
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_rx_ready", 32'(rx_ready), 1);
    endtask

    // Sends header, the words in words_q and (when enabled) the checksum.
    task automatic run_load(input int gap_max, input bit corrupt);
        logic [7:0]  x;
        logic [31:0] tmp;
        x = 8'h00;
        send_byte(8'(words_q.size()), 0);
        for (int i = 0; i < words_q.size(); i++) begin
            exp_addr_q.push_back(32'(i));
            exp_q.push_back(words_q[i]);
            for (int k = 3; k >= 0; k--) begin
                tmp = words_q[i] >> (8 * k);
                x = x ^ tmp[7:0];
                send_byte(tmp[7:0], $urandom_range(0, gap_max));
            end
        end
        data_last_accept = last_accept_cyc;
`ifdef LOADER_CHECKSUM_EN
        send_byte(corrupt ? (x ^ 8'h01) : x, $urandom_range(0, gap_max));
`else
        if (corrupt) x = x ^ 8'h01;
`endif
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        #1;
        while (done !== 1'b1 && error !== 1'b1 && t < 20) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (t >= 20) check("end_timeout", 32'(done | error), 32'd1);
    endtask

    task automatic check_final(input string tag, input bit ok);
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_error"}, 32'(error), 32'(!ok));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
        check({tag, "_rx_ready"}, 32'(rx_ready), 0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        check({tag, "_last_we_timing"}, last_we_cyc, data_last_accept);
        if (ok) begin
`ifdef LOADER_CHECKSUM_EN
            check({tag, "_done_timing"}, done_rise_cyc, last_accept_cyc);
`else
            check({tag, "_done_timing"}, done_rise_cyc, last_we_cyc + 1);
`endif
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clock);
        check_reset_state();
        reset = 1'b0;

        // Reference two-word program, continuous stream
        words_q = '{32'h2001_0005, 32'h0022_1020};
        run_load(0, 1'b0);
        wait_end();
        check_final("ref", 1'b1);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: writes still happen, load fails
        do_reset();
        reset = 1'b0;
        run_load(0, 1'b1);
        wait_end();
        check_final("badsum", 1'b0);
`endif

        // Zero-length header
        do_reset();
        reset = 1'b0;
        send_byte(8'h00, 0);
        #1;
        check("hdr0_error", 32'(error), 1);
        check("hdr0_rx_ready", 32'(rx_ready), 0);
        check("hdr0_cpu_reset", 32'(cpu_reset), 1);
        offer_ignored(8'h55);
        repeat (3) @(negedge clock);
        check("hdr0_done", 32'(done), 0);

        // Header larger than memory
        do_reset();
        reset = 1'b0;
        send_byte(8'(IMS + 1), 0);
        #1;
        check("hdr33_error", 32'(error), 1);
        check("hdr33_rx_ready", 32'(rx_ready), 0);
        repeat (3) @(negedge clock);

        // Reference program with rx_valid toggling every other cycle
        do_reset();
        reset = 1'b0;
        words_q = '{32'h2001_0005, 32'h0022_1020};
        run_load(1, 1'b0);
        wait_end();
        check_final("gapped", 1'b1);

        // Reset mid-load: only the completed first word is written
        do_reset();
        reset = 1'b0;
        send_byte(8'h02, 0);
        exp_addr_q.push_back(0);
        exp_q.push_back(32'h2001_0005);
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        do_reset();
        check_reset_state();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        words_q = '{32'hCAFE_0001};
        run_load(0, 1'b0);
        wait_end();
        check_final("after_abort", 1'b1);
        check("after_abort_addr", last_we_addr, 0);

        // Full memory, then trailing bytes must be ignored
        do_reset();
        reset = 1'b0;
        words_q.delete();
        for (int k = 0; k < IMS; k++) words_q.push_back(32'h1000_0000 + 32'(k));
        run_load(0, 1'b0);
        wait_end();
        check_final("full", 1'b1);
        check("full_last_addr", last_we_addr, 32'(IMS - 1));
        check("full_last_data", last_we_data, 32'h1000_001F);
        for (int k = 0; k < 4; k++) offer_ignored(8'($urandom));
        #1;
        check("full_done_held", 32'(done), 1);
        check("full_cpu_reset_held", 32'(cpu_reset), 0);

        // Random loads with random gaps
        for (int it = 0; it < 4; it++) begin
            do_reset();
            reset = 1'b0;
            words_q.delete();
            n = $urandom_range(1, IMS);
            for (int k = 0; k < n; k++) words_q.push_back($urandom);
            run_load(2, 1'b0);
            wait_end();
            check_final("random", 1'b1);
        end

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        reset = 1'b0;
        words_q.delete();
        n = $urandom_range(1, IMS);
        for (int k = 0; k < n; k++) words_q.push_back($urandom);
        run_load(2, 1'b1);
        wait_end();
        check_final("random_badsum", 1'b0);
`endif

        do_reset();
        reset = 1'b0;
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
